// File: rtl/ah_encoder_25_4.sv
// Egress address encoder: round-robin over client requests, emits REGION_BASE + client*2^OFFSET_W + offset.
// Optional AH_ENC_PARITY_EN adds egress_parity (XOR of egress_pkt_field), registered with the field.
module ah_encoder_25_4 #(
    parameter int unsigned            PKT_W       = 25,
    parameter int unsigned            NUM_CLIENTS = 4,
    parameter int unsigned            OFFSET_W    = 12,
    parameter logic [PKT_W-1:0]       REGION_BASE = '0,
    parameter logic [NUM_CLIENTS-1:0] CLIENT_MASK = '1,
    localparam int unsigned           ID_W        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CLIENTS-1:0]          client_req,
    input  logic [NUM_CLIENTS*OFFSET_W-1:0] client_offset,
    output logic [NUM_CLIENTS-1:0]          client_gnt,
    output logic                            egress_valid,
    input  logic                            egress_ready,
    output logic [PKT_W-1:0]                egress_pkt_field,
    output logic [ID_W-1:0]                 egress_client_id,
    output logic                            enc_err
`ifdef AH_ENC_PARITY_EN
    ,
    output logic                            egress_parity
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic [PKT_W-1:0]       field_q, field_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
    logic [NUM_CLIENTS-1:0] req_q;
    logic                   err_q, err_d;

    logic [NUM_CLIENTS-1:0] eligible;
    logic                   found;
    logic [ID_W-1:0]        win;
    logic [OFFSET_W-1:0]    win_off;
    logic [PKT_W-1:0]       win_field;
    logic                   load;

    // The client pulsing its grant this cycle still holds req high, so it is masked out here.
    assign eligible = client_req & CLIENT_MASK & ~gnt_q;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            idx = (32'(ptr_q) + i) % NUM_CLIENTS;
            if (!found && eligible[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign win_off   = client_offset[win*OFFSET_W +: OFFSET_W];
    assign win_field = REGION_BASE + (PKT_W'(win) << OFFSET_W) + PKT_W'(win_off);
    assign load      = found && ((state_q == ST_IDLE) || egress_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        field_d = field_q;
        id_d    = id_q;
        gnt_d   = '0;
        if (load) begin
            state_d = ST_HOLD;
            ptr_d   = ID_W'((32'(win) + 1) % NUM_CLIENTS);
            valid_d = 1'b1;
            field_d = win_field;
            id_d    = win;
            gnt_d   = NUM_CLIENTS'(1) << win;
        end else if ((state_q == ST_HOLD) && egress_ready) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end
    end

    assign err_d = |(client_req & ~req_q & ~CLIENT_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            field_q <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            field_q <= field_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            req_q   <= client_req;
            err_q   <= err_d;
        end
    end

    assign client_gnt       = gnt_q;
    assign egress_valid     = valid_q;
    assign egress_pkt_field = field_q;
    assign egress_client_id = id_q;
    assign enc_err          = err_q;

`ifdef AH_ENC_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = load ? ^win_field : parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign egress_parity = parity_q;
`endif

endmodule
